pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Drives the fetch side of the multi-cycle core: owns the program counter and issues one
//  fetch request (pc_o + valid_o) per instruction. Sits in front of the fetch stage.
//  Waits for the in-flight instruction to retire, then advances sequentially or redirects
//  on branch/jump. One instruction in flight at a time.
// PARAMETERS
//  ADDR_WIDTH   params_pkg::ADDR_WIDTH (32)  PC / address width
//  RESET_PC     '0                           PC loaded on reset
//  INSTR_BYTES  4                            PC increment; power of two
//  COUNT_WIDTH  32                           width of retired-instruction counter
// PORTS
//  clk_i               in   1            clock, all state on rising edge
//  rst_ni              in   1            asynchronous reset, active-low
//  stall_i             in   1            fetch/decode cannot accept request this cycle
//  retire_i            in   1            in-flight instruction completed (1-cycle pulse)
//  alu_branch_taken_i  in   1            retiring instr is a taken branch (qualified by retire_i)
//  is_jump_i           in   1            retiring instr is a jump (qualified by retire_i)
//  target_i            in   ADDR_WIDTH   redirect target (qualified by retire_i & redirect)
//  halt_i              in   1            retiring instr is a halt (qualified by retire_i)
//  pc_o                out  ADDR_WIDTH   address of current fetch request
//  valid_o             out  1            fetch request valid
//  halted_o            out  1            sequencer halted
//  misalign_o          out  1            1-cycle pulse: redirect target was misaligned
//  retired_cnt_o       out  COUNT_WIDTH  count of retired instructions
// BEHAVIOUR
//  Reset (async, rst_ni=0): state=BOOT, pc_o=RESET_PC, valid_o=0, halted_o=0,
//   misalign_o=0, retired_cnt_o=0. Takes effect immediately, in any state.
//  States: BOOT, FETCH, WAIT, HALT.
//  BOOT: one cycle after reset release, valid_o=0 -> FETCH.
//  FETCH: valid_o=1, pc_o stable. stall_i=1 -> stay FETCH (request held). stall_i=0 ->
//   request accepted this cycle -> WAIT. retire_i in FETCH ignored (nothing in flight).
//  WAIT: valid_o=0. retire_i=0 -> stay. retire_i=1: retired_cnt_o += 1 (wraps mod
//   2^COUNT_WIDTH); then priority:
//   1) halt_i=1 -> HALT (pc_o unchanged; redirect inputs ignored).
//   2) alu_branch_taken_i | is_jump_i -> pc_o <= target_i with low log2(INSTR_BYTES) bits
//      forced to 0; misalign_o=1 next cycle if any of those bits were set -> FETCH.
//   3) else pc_o <= pc_o + INSTR_BYTES, wrapping mod 2^ADDR_WIDTH -> FETCH.
//  HALT: valid_o=0, halted_o=1, pc_o frozen; all inputs ignored until reset.
//  Latency: retire_i in WAIT -> valid_o=1 with new pc_o on the next cycle.
//   Minimum issue interval 2 cycles (FETCH + 1 cycle WAIT).
//  misalign_o is high for exactly one cycle, concurrent with the first FETCH cycle.
//  Branch and jump asserted together: single redirect to target_i.
//  valid_o and pc_o are registered outputs (no combinational path from inputs).
// TESTING
//  1 Reset release, stall_i=0 -> valid_o=0 in BOOT cycle, then valid_o=1, pc_o=0x0.
//  2 Three retires, no redirect -> fetch pcs 0x0, 0x4, 0x8; retired_cnt_o=3.
//  3 Retire with is_jump_i=1, target_i=0x40 -> next fetch pc_o=0x40, misalign_o=0.
//  4 Retire with alu_branch_taken_i=1, target_i=0x42 -> pc_o=0x40, misalign_o pulse 1 cycle.
//  5 stall_i=1 for 3 cycles in FETCH -> valid_o=1, pc_o constant for 4 cycles, then WAIT.
//  6 pc_o=0xFFFFFFFC, sequential retire -> pc_o=0x0; halt_i retire -> halted_o=1,
//    valid_o=0 forever; rst_ni low mid-WAIT -> all outputs reset same cycle.

Source files
------------

// File: rtl/pc_sequencer.sv
// Fetch-side program counter sequencer: issues one fetch request per instruction,
// waits for it to retire, then steps sequentially or redirects on branch/jump.
module pc_sequencer #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter int                    INSTR_BYTES = 4,
  parameter int                    COUNT_WIDTH = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   stall_i,
  input  logic                   retire_i,
  input  logic                   alu_branch_taken_i,
  input  logic                   is_jump_i,
  input  logic [ADDR_WIDTH-1:0]  target_i,
  input  logic                   halt_i,
  output logic [ADDR_WIDTH-1:0]  pc_o,
  output logic                   valid_o,
  output logic                   halted_o,
  output logic                   misalign_o,
  output logic [COUNT_WIDTH-1:0] retired_cnt_o,
  output logic [1:0]             state_o
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0]  ALIGN_MASK = ADDR_WIDTH'(INSTR_BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0]  PC_STEP    = ADDR_WIDTH'(INSTR_BYTES);
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE    = COUNT_WIDTH'(1);

  state_t                 state_q;
  logic [ADDR_WIDTH-1:0]  pc_q;
  logic                   valid_q;
  logic                   halted_q;
  logic                   misalign_q;
  logic [COUNT_WIDTH-1:0] cnt_q;

  logic                   redirect_d;
  logic [ADDR_WIDTH-1:0]  seq_pc_d;
  logic [ADDR_WIDTH-1:0]  redir_pc_d;
  logic                   misalign_d;

  assign redirect_d = alu_branch_taken_i | is_jump_i;
  assign seq_pc_d   = pc_q + PC_STEP;
  assign redir_pc_d = target_i & ~ALIGN_MASK;
  assign misalign_d = |(target_i & ALIGN_MASK);

  // Handshake: valid_o stays high with a stable pc_o until a cycle in which
  // stall_i is low; that cycle is the acceptance and the request is then in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_PC;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
      misalign_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      misalign_q <= 1'b0;
      case (state_q)
        S_BOOT: begin
          state_q <= S_FETCH;
          valid_q <= 1'b1;
        end
        S_FETCH: begin
          if (!stall_i) begin
            state_q <= S_WAIT;
            valid_q <= 1'b0;
          end
        end
        S_WAIT: begin
          if (retire_i) begin
            cnt_q <= cnt_q + CNT_ONE;
            if (halt_i) begin
              state_q  <= S_HALT;
              halted_q <= 1'b1;
            end else begin
              state_q <= S_FETCH;
              valid_q <= 1'b1;
              if (redirect_d) begin
                pc_q       <= redir_pc_d;
                misalign_q <= misalign_d;
              end else begin
                pc_q <= seq_pc_d;
              end
            end
          end
        end
        S_HALT: begin
          state_q <= S_HALT;
        end
        default: begin
          state_q <= S_BOOT;
        end
      endcase
    end
  end

  assign pc_o          = pc_q;
  assign valid_o       = valid_q;
  assign halted_o      = halted_q;
  assign misalign_o    = misalign_q;
  assign retired_cnt_o = cnt_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed instruction sequences, a request/in-flight
// reference model compared every cycle, plus hand-computed literal expectations.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        retire;
  logic        br;
  logic        jmp;
  logic [31:0] tgt;
  logic        hlt;
  logic [31:0] pc;
  logic        valid;
  logic        halted;
  logic        mis;
  logic [31:0] cnt;
  logic [1:0]  state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  pc_sequencer dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .stall_i            (stall),
    .retire_i           (retire),
    .alu_branch_taken_i (br),
    .is_jump_i          (jmp),
    .target_i           (tgt),
    .halt_i             (hlt),
    .pc_o               (pc),
    .valid_o            (valid),
    .halted_o           (halted),
    .misalign_o         (mis),
    .retired_cnt_o      (cnt),
    .state_o            (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, act=running exp=finished");
    $fatal(1, "watchdog");
  end

  // reference model: a fetch request is either being presented, in flight,
  // or the sequencer has stopped; boot costs one idle cycle after reset
  logic        m_boot, m_req, m_inflight, m_halt, m_mis;
  logic [31:0] m_pc, m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_boot = 1'b1; m_req = 1'b0; m_inflight = 1'b0; m_halt = 1'b0;
      m_mis = 1'b0; m_pc = 32'h0; m_cnt = 32'h0;
    end else begin
      m_mis = 1'b0;
      if (m_halt) begin
        m_halt = 1'b1;
      end else if (m_boot) begin
        m_boot = 1'b0;
        m_req  = 1'b1;
      end else if (m_req) begin
        if (!stall) begin
          m_req      = 1'b0;
          m_inflight = 1'b1;
        end
      end else if (m_inflight && retire) begin
        m_cnt      = m_cnt + 32'd1;
        m_inflight = 1'b0;
        if (hlt) begin
          m_halt = 1'b1;
        end else begin
          m_req = 1'b1;
          if (br || jmp) begin
            m_mis = (tgt % 32'd4) != 32'd0;
            m_pc  = (tgt / 32'd4) * 32'd4;
          end else begin
            m_pc = m_pc + 32'd4;
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: act=0x%08h exp=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // compare process, away from the active edge
  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_pc",     pc,            m_pc);
      check("model_valid",  {31'd0, valid}, {31'd0, m_req});
      check("model_halted", {31'd0, halted}, {31'd0, m_halt});
      check("model_mis",    {31'd0, mis},   {31'd0, m_mis});
      check("model_cnt",    cnt,           m_cnt);
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic retire_one(input logic b, input logic j, input logic h, input logic [31:0] t);
    retire = 1'b1; br = b; jmp = j; hlt = h; tgt = t;
    tick();
    retire = 1'b0; br = 1'b0; jmp = 1'b0; hlt = 1'b0; tgt = 32'h0;
  endtask

  // precondition: just after an edge with the request presented
  task automatic instr(input int nstall, input int nwait,
                       input logic b, input logic j, input logic h, input logic [31:0] t);
    stall = 1'b1;
    repeat (nstall) tick();
    stall = 1'b0;
    tick();
    repeat (nwait) tick();
    retire_one(b, j, h, t);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; retire = 1'b0; br = 1'b0; jmp = 1'b0;
    tgt = 32'h0; hlt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cmp_en = 1'b1;
    check("rst_valid",  {31'd0, valid},  32'd0);
    check("rst_pc",     pc,              32'h0);
    check("rst_cnt",    cnt,             32'd0);
    rst_n = 1'b1;
    check("boot_valid", {31'd0, valid},  32'd0);
    tick();
    check("first_valid", {31'd0, valid}, 32'd1);
    check("first_pc",    pc,             32'h0);

    instr(0, 0, 0, 0, 0, 32'h0);  check("seq_pc4", pc, 32'h4);
    instr(0, 2, 0, 0, 0, 32'h0);  check("seq_pc8", pc, 32'h8);
    instr(0, 0, 0, 0, 0, 32'h0);  check("seq_cnt3", cnt, 32'd3);

    instr(0, 1, 0, 1, 0, 32'h40);
    check("jump_pc",  pc, 32'h40);
    check("jump_mis", {31'd0, mis}, 32'd0);

    instr(0, 0, 1, 0, 0, 32'h42);
    check("branch_pc",  pc, 32'h40);
    check("branch_mis", {31'd0, mis}, 32'd1);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_valid", {31'd0, valid}, 32'd1);
      check("stall_pc",    pc, 32'h40);
      if (i == 0) check("mis_one_cycle", {31'd0, mis}, 32'd0);
    end
    stall = 1'b0;
    tick();
    check("accept_valid", {31'd0, valid}, 32'd0);
    retire_one(0, 0, 0, 32'h0);
    check("after_stall_pc", pc, 32'h44);

    retire_one(0, 0, 0, 32'h0);
    check("fetch_retire_ignored", cnt, 32'd6);
    retire_one(0, 0, 0, 32'h0);
    check("seq_pc48", pc, 32'h48);

    instr(0, 0, 1, 1, 0, 32'h101);
    check("both_pc",  pc, 32'h100);
    check("both_mis", {31'd0, mis}, 32'd1);

    instr(0, 0, 0, 1, 0, 32'hFFFF_FFFC);
    check("top_pc", pc, 32'hFFFF_FFFC);
    instr(1, 0, 0, 0, 0, 32'h0);
    check("wrap_pc",  pc, 32'h0);
    check("wrap_cnt", cnt, 32'd10);

    instr(0, 0, 1, 1, 1, 32'h200);
    check("halt_flag",  {31'd0, halted}, 32'd1);
    check("halt_valid", {31'd0, valid}, 32'd0);
    check("halt_pc",    pc, 32'h0);
    check("halt_cnt",   cnt, 32'd11);
    for (int i = 0; i < 10; i++) begin
      stall = 1'($urandom_range(0, 1)); retire = 1'($urandom_range(0, 1));
      br = 1'($urandom_range(0, 1)); jmp = 1'($urandom_range(0, 1));
      hlt = 1'($urandom_range(0, 1)); tgt = $urandom;
      tick();
      check("halt_hold_valid", {31'd0, valid}, 32'd0);
      check("halt_hold_pc",    pc, 32'h0);
    end
    stall = 1'b0; retire = 1'b0; br = 1'b0; jmp = 1'b0; hlt = 1'b0; tgt = 32'h0;

    #2 rst_n = 1'b0;
    #1 check("halt_rst_flag", {31'd0, halted}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    instr(0, 0, 0, 0, 0, 32'h0);
    check("post_rst_pc", pc, 32'h4);
    tick();
    #3 rst_n = 1'b0;
    #1;
    check("midwait_rst_pc",    pc, 32'h0);
    check("midwait_rst_cnt",   cnt, 32'd0);
    check("midwait_rst_valid", {31'd0, valid}, 32'd0);
    check("midwait_rst_mis",   {31'd0, mis}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) begin
      instr($urandom_range(0, 2), $urandom_range(0, 3),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, $urandom);
    end
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
